// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM multiplexer: FSM state encoding, default
// sizing constants and the select-width helper.
package tdm_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NCH_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Select width never drops below one bit, even for a two-channel build.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/next_ch_find.sv
// Combinational search: lowest set bit of mask_i at or above from_i.
// from_i is one bit wider than an index so "one past the last channel" is representable.
module next_ch_find #(
    parameter int NCH  = 8,
    parameter int SELW = 3
) (
    input  logic [NCH-1:0]  mask_i,
    input  logic [SELW:0]   from_i,
    output logic [SELW-1:0] idx_o,
    output logic            found_o
);

    // Walking downward lets the lowest qualifying index overwrite any higher one.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask_i[k] && (k >= int'(from_i))) begin
                found_o = 1'b1;
                idx_o   = k[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/tdm_mux.sv
// Registered N-channel multiplexer with a manual select mode and a masked,
// ascending-order scan mode that ends with a one-cycle done pulse.
module tdm_mux
    import tdm_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int NCH   = NCH_DEF,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] w,
    input  logic [SELW-1:0]      s,
    input  logic                 mode,
    input  logic [NCH-1:0]       en_mask,
    input  logic                 start,
    output logic [WIDTH-1:0]     f,
    output logic [SELW-1:0]      ch,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    state_e            state_q;
    logic [NCH-1:0]    mask_q;
    logic [WIDTH-1:0]  f_q;
    logic [SELW-1:0]   ch_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  w_arr [NCH];
    logic              idle;
    logic              s_in_range;
    logic [NCH-1:0]    fnd_mask;
    logic [SELW:0]     fnd_from;
    logic [SELW-1:0]   fnd_idx;
    logic              fnd_found;
    logic [SELW-1:0]   sel_idx;
    logic [WIDTH-1:0]  sel_data;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign w_arr[gi] = w[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // In IDLE the finder looks at the live mask from channel 0 (first pick of a
    // new scan); in SCAN it continues from just above the channel on the output.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        s_in_range = (int'(s) < NCH);
        fnd_mask   = idle ? en_mask : mask_q;
        fnd_from   = idle ? '0 : ({1'b0, ch_q} + (SELW+1)'(1));
        sel_idx    = (idle && !mode) ? s : fnd_idx;
        sel_data   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel_idx) == k) begin
                sel_data = w_arr[k];
            end
        end
    end

    next_ch_find #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_find (
        .mask_i  (fnd_mask),
        .from_i  (fnd_from),
        .idx_o   (fnd_idx),
        .found_o (fnd_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            f_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (!mode) begin
                        ch_q    <= s;
                        f_q     <= s_in_range ? sel_data : '0;
                        valid_q <= s_in_range;
                    end else if (start) begin
                        mask_q <= en_mask;
                        if (fnd_found) begin
                            f_q     <= sel_data;
                            ch_q    <= fnd_idx;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ST_SCAN;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (fnd_found) begin
                        f_q     <= sel_data;
                        ch_q    <= fnd_idx;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign f     = f_q;
    assign ch    = ch_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: an 8-channel and a 5-channel instance share
// stimulus and are checked every cycle against a queue-free behavioural model.
module tb_tdm_mux;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        start;
    logic [31:0] w;
    logic [2:0]  s;
    logic [7:0]  en;

    logic [3:0]  f8, f5;
    logic [2:0]  ch8, ch5;
    logic        v8, b8, d8, v5, b5, d5;

    int n_total;
    int n_pass;

    // Model state per instance: 0 = idle, 1 = scanning, 2 = finishing.
    int ph  [2];
    int rem [2];
    int ef  [2];
    int ech [2];
    int ev  [2];
    int eb  [2];
    int ed  [2];

    tdm_mux u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .w       (w),
        .s       (s),
        .mode    (mode),
        .en_mask (en),
        .start   (start),
        .f       (f8),
        .ch      (ch8),
        .valid   (v8),
        .busy    (b8),
        .done    (d8)
    );

    tdm_mux #(.WIDTH(4), .NCH(5)) u_dut5 (
        .clk     (clk),
        .rst     (rst),
        .w       (w[19:0]),
        .s       (s),
        .mode    (mode),
        .en_mask (en[4:0]),
        .start   (start),
        .f       (f5),
        .ch      (ch5),
        .valid   (v5),
        .busy    (b5),
        .done    (d5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int chan(input int k);
        return int'((w >> (4 * k)) & 32'hF);
    endfunction

    // Emit the lowest still-pending channel of instance d.
    task automatic emit(input int d);
        int k;
        k = 0;
        while (((rem[d] >> k) & 1) == 0) k++;
        rem[d] = rem[d] & ~(1 << k);
        ef[d] = chan(k); ech[d] = k; ev[d] = 1; eb[d] = 1; ed[d] = 0;
    endtask

    task automatic model_step(input int d, input int nch);
        if (rst) begin
            ph[d] = 0; rem[d] = 0; ef[d] = 0; ech[d] = 0; ev[d] = 0; eb[d] = 0; ed[d] = 0;
        end else if (ph[d] == 0) begin
            ed[d] = 0; eb[d] = 0;
            if (!mode) begin
                ech[d] = int'(s);
                if (int'(s) < nch) begin ef[d] = chan(int'(s)); ev[d] = 1; end
                else begin ef[d] = 0; ev[d] = 0; end
            end else if (start) begin
                rem[d] = int'(en) & ((1 << nch) - 1);
                if (rem[d] == 0) begin ev[d] = 0; ed[d] = 1; ph[d] = 2; end
                else begin emit(d); ph[d] = 1; end
            end else begin
                ev[d] = 0;
            end
        end else if (ph[d] == 1) begin
            if (rem[d] != 0) emit(d);
            else begin ev[d] = 0; eb[d] = 0; ed[d] = 1; ph[d] = 2; end
        end else begin
            ev[d] = 0; eb[d] = 0; ed[d] = 0; ph[d] = 0;
        end
    endtask

    task automatic compare_all();
        chk("dut8.f",     int'(f8),  ef[0]);
        chk("dut8.ch",    int'(ch8), ech[0] & 7);
        chk("dut8.valid", int'(v8),  ev[0]);
        chk("dut8.busy",  int'(b8),  eb[0]);
        chk("dut8.done",  int'(d8),  ed[0]);
        chk("dut5.f",     int'(f5),  ef[1]);
        chk("dut5.ch",    int'(ch5), ech[1] & 7);
        chk("dut5.valid", int'(v5),  ev[1]);
        chk("dut5.busy",  int'(b5),  eb[1]);
        chk("dut5.done",  int'(d5),  ed[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 8);
        model_step(1, 5);
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int exp_seq [3];
        n_total = 0;
        n_pass  = 0;
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; rem[d] = 0; ef[d] = 0; ech[d] = 0; ev[d] = 0; eb[d] = 0; ed[d] = 0;
        end
        rst = 1'b1; mode = 1'b0; start = 1'b0; w = 32'h7654_3210; s = '0; en = '0;
        #2;
        tick();
        tick();
        chk("reset f", int'(f8), 0);
        chk("reset valid/busy/done", int'({v8, b8, d8}), 0);
        rst = 1'b0;

        // Manual mode walk over all channels.
        for (int i = 0; i < 8; i++) begin
            s = i[2:0];
            tick();
            chk("manual f", int'(f8), i);
            chk("manual ch", int'(ch8), i);
            chk("manual valid", int'(v8), 1);
            chk("manual busy", int'(b8), 0);
        end

        // Full scan.
        mode = 1'b1; en = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("fullscan ch", int'(ch8), i);
            chk("fullscan f", int'(f8), i);
            chk("fullscan valid", int'(v8), 1);
            tick();
        end
        chk("fullscan done", int'(d8), 1);
        chk("fullscan done valid", int'(v8), 0);
        tick();
        chk("fullscan after done", int'(d8), 0);

        // Sparse scan; mask change mid-scan must be ignored.
        exp_seq = '{2, 5, 7};
        en = 8'b1010_0100; start = 1'b1;
        tick();
        start = 1'b0; en = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("sparse ch", int'(ch8), exp_seq[i]);
            tick();
        end
        chk("sparse done", int'(d8), 1);
        tick();

        // Empty mask: done right away, never valid or busy.
        en = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty done", int'(d8), 1);
        chk("empty valid/busy", int'({v8, b8}), 0);
        tick();
        chk("empty after", int'(d8), 0);

        // Reset on the third scan cycle aborts without a done pulse.
        en = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort pre ch", int'(ch8), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort f/ch", int'({f8, ch8}), 0);
        chk("abort valid/busy/done", int'({v8, b8, d8}), 0);
        tick();
        chk("abort no done", int'(d8), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rescan first ch", int'(ch8), 0);
        n = 0;
        while (!d8 && n < 20) begin tick(); n++; end
        chk("rescan length", n, 8);
        tick();

        // Five-channel instance: out-of-range manual select.
        mode = 1'b0; s = 3'd6;
        tick();
        chk("nch5 f", int'(f5), 0);
        chk("nch5 valid", int'(v5), 0);
        chk("nch5 ch", int'(ch5), 6);

        // Five-channel scan with start re-pulsed while scanning.
        mode = 1'b1; en = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!d5 && n < 20) begin
            start = (n == 2 || n == 3);
            tick();
            n++;
        end
        start = 1'b0;
        chk("nch5 scan length", n, 6);
        for (int i = 0; i < 6; i++) tick();

        // Randomised traffic with live data changes.
        for (int i = 0; i < 1500; i++) begin
            w     = $urandom;
            s     = 3'($urandom_range(0, 7));
            mode  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 5))
                0:       en = 8'h00;
                1:       en = 8'hFF;
                default: en = 8'($urandom);
            endcase
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
